// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: memory-access stage that sits directly after the execute ALU.
// It takes one instruction at a time and handles it in one of three ways:
//   - A non-memory op passes its ALU result through to writeback.
//   - A misaligned or illegal access is answered with Err_o and touches no memory.
//   - A load or store is issued on a request/grant/rvalid data-memory port.
// Each instruction produces one registered result on a valid/ready writeback
// port, except when it is flushed.
//
// Ports:
//   clk_i, rst_ni                 clock (rising edge), async active-low reset
//   Valid_i / Ready_o             instruction handshake from execute
//   ALUResult_i, StoreData_i      effective address or result, store data (rs2)
//   MemRead_i, MemWrite_i         load / store select
//   Funct3_i                      size and sign: B, H, W, BU, HU
//   RegWrite_i, Rd_i              destination write enable and register index
//   Flush_i                       squash the in-flight instruction
//   MemReq_o .. MemWData_o        memory request (word address, byte enables,
//                                 lane-replicated write data)
//   MemGnt_i, MemRValid_i,
//   MemRData_i                    memory grant and read response
//   WbValid_o / WbReady_i         result handshake to writeback
//   WbData_o, WbRd_o, WbWe_o      result data, destination, write enable
//   Err_o                         misaligned or illegal access (valid only
//                                 while WbValid_o is high)
module lsu_mem_stage #(
    parameter int DATAWIDTH     = 32,
    parameter int REGADDR_WIDTH = 5
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     Valid_i,
    output logic                     Ready_o,
    input  logic [DATAWIDTH-1:0]     ALUResult_i,
    input  logic [DATAWIDTH-1:0]     StoreData_i,
    input  logic                     MemRead_i,
    input  logic                     MemWrite_i,
    input  logic [2:0]               Funct3_i,
    input  logic                     RegWrite_i,
    input  logic [REGADDR_WIDTH-1:0] Rd_i,
    input  logic                     Flush_i,
    output logic                     MemReq_o,
    output logic                     MemWe_o,
    output logic [DATAWIDTH-1:0]     MemAddr_o,
    output logic [3:0]               MemBe_o,
    output logic [DATAWIDTH-1:0]     MemWData_o,
    input  logic                     MemGnt_i,
    input  logic                     MemRValid_i,
    input  logic [DATAWIDTH-1:0]     MemRData_i,
    output logic                     WbValid_o,
    input  logic                     WbReady_i,
    output logic [DATAWIDTH-1:0]     WbData_o,
    output logic [REGADDR_WIDTH-1:0] WbRd_o,
    output logic                     WbWe_o,
    output logic                     Err_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t                 state;
    logic [2:0]             funct3_q;
    logic [1:0]             off_q;
    logic                   reg_write_q;
    logic                   is_store_q;
    logic                   drop_q;
    logic [DATAWIDTH-1:0]   alu_q;

    logic                   mem_op;
    logic                   f3_legal;
    logic                   misaligned;
    logic                   access_err;
    logic [3:0]             be_next;
    logic [DATAWIDTH-1:0]   wdata_next;
    logic [DATAWIDTH-1:0]   lane_word;
    logic [DATAWIDTH-1:0]   load_data;

    // A new instruction is taken only when the stage is idle and has no result pending.
    assign Ready_o = (state == IDLE) && !WbValid_o;

    // Decode the incoming instruction.
    // Legality: stores accept only B/H/W; loads also accept BU/HU.
    // Alignment: halves must sit on even addresses, words on multiples of 4.
    // Byte enables and replicated write data use the address offset and the size.
    always_comb begin
        mem_op = MemRead_i | MemWrite_i;

        case (Funct3_i)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = !MemWrite_i;
            default:                f3_legal = 1'b0;
        endcase

        case (Funct3_i[1:0])
            2'b01:   misaligned = ALUResult_i[0];
            2'b10:   misaligned = |ALUResult_i[1:0];
            default: misaligned = 1'b0;
        endcase

        access_err = mem_op && (!f3_legal || misaligned);

        case (Funct3_i[1:0])
            2'b00: begin
                be_next    = 4'b0001 << ALUResult_i[1:0];
                wdata_next = {4{StoreData_i[7:0]}};
            end
            2'b01: begin
                be_next    = 4'b0011 << ALUResult_i[1:0];
                wdata_next = {2{StoreData_i[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = StoreData_i;
            end
        endcase
    end

    // Load result formatting.
    // Shift the addressed lane down to bit 0.
    // Then sign- or zero-extend it according to the latched funct3.
    always_comb begin
        lane_word = MemRData_i >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_data = {{24{lane_word[7]}}, lane_word[7:0]};
            3'b100:  load_data = {24'h0, lane_word[7:0]};
            3'b001:  load_data = {{16{lane_word[15]}}, lane_word[15:0]};
            3'b101:  load_data = {16'h0, lane_word[15:0]};
            default: load_data = MemRData_i;
        endcase
    end

    // Main control FSM; every memory and writeback output is registered here.
    // drop_q marks a load that was flushed after its grant. The memory will
    // still return that read, and the stage must absorb it without producing
    // a result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            reg_write_q <= 1'b0;
            is_store_q  <= 1'b0;
            drop_q      <= 1'b0;
            alu_q       <= '0;
            MemReq_o    <= 1'b0;
            MemWe_o     <= 1'b0;
            MemAddr_o   <= '0;
            MemBe_o     <= 4'b0000;
            MemWData_o  <= '0;
            WbValid_o   <= 1'b0;
            WbData_o    <= '0;
            WbRd_o      <= '0;
            WbWe_o      <= 1'b0;
            Err_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Valid_i && Ready_o && !Flush_i) begin
                        WbRd_o      <= Rd_i;
                        funct3_q    <= Funct3_i;
                        off_q       <= ALUResult_i[1:0];
                        reg_write_q <= RegWrite_i;
                        is_store_q  <= MemWrite_i;
                        alu_q       <= ALUResult_i;
                        drop_q      <= 1'b0;
                        Err_o       <= 1'b0;
                        if (!mem_op) begin
                            state     <= RESP;
                            WbValid_o <= 1'b1;
                            WbData_o  <= ALUResult_i;
                            WbWe_o    <= RegWrite_i;
                        end else if (access_err) begin
                            state     <= RESP;
                            WbValid_o <= 1'b1;
                            WbData_o  <= ALUResult_i;
                            WbWe_o    <= 1'b0;
                            Err_o     <= 1'b1;
                        end else begin
                            state      <= REQ;
                            MemReq_o   <= 1'b1;
                            MemWe_o    <= MemWrite_i;
                            MemAddr_o  <= {ALUResult_i[DATAWIDTH-1:2], 2'b00};
                            MemBe_o    <= be_next;
                            MemWData_o <= wdata_next;
                        end
                    end
                end
                REQ: begin
                    if (MemGnt_i) begin
                        MemReq_o <= 1'b0;
                        if (is_store_q) begin
                            if (Flush_i) begin
                                state <= IDLE;
                            end else begin
                                state     <= RESP;
                                WbValid_o <= 1'b1;
                                WbData_o  <= alu_q;
                                WbWe_o    <= 1'b0;
                            end
                        end else if (MemRValid_i) begin
                            // Read data arrived together with the grant. If a
                            // flush came in the same cycle, that data has already
                            // been consumed, so go straight back to IDLE.
                            if (Flush_i) begin
                                state <= IDLE;
                            end else begin
                                state     <= RESP;
                                WbValid_o <= 1'b1;
                                WbData_o  <= load_data;
                                WbWe_o    <= reg_write_q;
                            end
                        end else begin
                            state  <= WAIT;
                            drop_q <= Flush_i;
                        end
                    end else if (Flush_i) begin
                        MemReq_o <= 1'b0;
                        state    <= IDLE;
                    end
                end
                WAIT: begin
                    if (MemRValid_i) begin
                        if (drop_q || Flush_i) begin
                            drop_q <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            state     <= RESP;
                            WbValid_o <= 1'b1;
                            WbData_o  <= load_data;
                            WbWe_o    <= reg_write_q;
                        end
                    end else if (Flush_i) begin
                        drop_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (Flush_i || WbReady_i) begin
                        WbValid_o <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
